// File: rtl/driver_mon_pkg.sv
// driver_mon_pkg: width helper and gap-to-bin mapping shared by the driver monitors
package driver_mon_pkg;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int gap_bin(input int gap, input int cnt_range, input int max_cycle);
    return gap < max_cycle ? gap / cnt_range : max_cycle / cnt_range;
  endfunction
endpackage

// File: rtl/gap_hist_chan.sv
// gap_hist_chan: one channel's strobe-to-strobe gap counter, saturating bin array (last bin = overflow), sticky saturation flag and 32-bit event total; rd_val is an unregistered view of bin rd_bin
module gap_hist_chan
  import driver_mon_pkg::*;
#(
  parameter int CNT_RANGE = 8,
  parameter int CNT_SIZE = 16,
  parameter int MAX_CYCLE_CNT = 128,
  localparam int NUM_BINS = MAX_CYCLE_CNT / CNT_RANGE,
  localparam int BIN_W = $clog2(NUM_BINS + 1),
  localparam int GAP_W = $clog2(MAX_CYCLE_CNT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                arm,
  input  logic                clr,
  input  logic                ev,
  input  logic [BIN_W-1:0]    rd_bin,
  output logic [CNT_SIZE-1:0] rd_val,
  output logic                sat,
  output logic [31:0]         total
);
  logic [GAP_W-1:0] gap_q, gap_d;
  logic primed_q, primed_d, sat_q, sat_d;
  logic [31:0] total_q, total_d;
  logic [CNT_SIZE-1:0] bins_q [NUM_BINS+1];
  logic [CNT_SIZE-1:0] bins_d [NUM_BINS+1];
  logic [BIN_W-1:0] bin;
  assign bin = BIN_W'(gap_bin(int'(gap_q), CNT_RANGE, MAX_CYCLE_CNT));
  assign rd_val = rd_bin <= BIN_W'(NUM_BINS) ? bins_q[rd_bin] : '0;
  assign sat = sat_q;
  assign total = total_q;
  always_comb begin
    gap_d = gap_q;
    primed_d = primed_q;
    bins_d = bins_q;
    sat_d = sat_q;
    total_d = total_q;
    if (clr) begin
      gap_d = '0;
      primed_d = 1'b0;
      bins_d = '{default: '0};
      sat_d = 1'b0;
      total_d = '0;
    end else if (!run) begin
      primed_d = 1'b0;
    end else if (ev) begin
      total_d = total_q + 32'd1;
      gap_d = GAP_W'(1);
      primed_d = 1'b1;
      if (primed_q) begin
        bins_d[bin] = &bins_q[bin] ? bins_q[bin] : bins_q[bin] + CNT_SIZE'(1);
        sat_d = sat_q | (&bins_d[bin]);
      end
    end else begin
      gap_d = arm ? '0 : gap_q == GAP_W'(MAX_CYCLE_CNT) ? gap_q : gap_q + GAP_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0;
      primed_q <= 1'b0;
      bins_q <= '{default: '0};
      sat_q <= 1'b0;
      total_q <= '0;
    end else begin
      gap_q <= gap_d;
      primed_q <= primed_d;
      bins_q <= bins_d;
      sat_q <= sat_d;
      total_q <= total_d;
    end
  end
endmodule

// File: rtl/driver_gap_histogram.sv
// driver_gap_histogram: NUM_CH event-gap histograms (ev, run_program, hist_clear in) with a 1-cycle read port (rd_en/rd_ch/rd_bin -> rd_data/rd_valid), sticky sat_flag and ev_total readback
module driver_gap_histogram
  import driver_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_RANGE = 8,
  parameter int CNT_SIZE = 16,
  parameter int MAX_CYCLE_CNT = 128,
  localparam int NUM_BINS = MAX_CYCLE_CNT / CNT_RANGE,
  localparam int BIN_W = $clog2(NUM_BINS + 1),
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_program,
  input  logic                 hist_clear,
  input  logic [NUM_CH-1:0]    ev,
  input  logic                 rd_en,
  input  logic [CH_W-1:0]      rd_ch,
  input  logic [BIN_W-1:0]     rd_bin,
  output logic [CNT_SIZE-1:0]  rd_data,
  output logic                 rd_valid,
  output logic [NUM_CH-1:0]    sat_flag,
  output logic [32*NUM_CH-1:0] ev_total
);
  logic run_q, arm;
  logic [CNT_SIZE-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic [CNT_SIZE-1:0] rd_vals [NUM_CH];
  assign arm = run_program & ~run_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    gap_hist_chan #(
      .CNT_RANGE(CNT_RANGE),
      .CNT_SIZE(CNT_SIZE),
      .MAX_CYCLE_CNT(MAX_CYCLE_CNT)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .run(run_program),
      .arm(arm),
      .clr(hist_clear),
      .ev(ev[c]),
      .rd_bin(rd_bin),
      .rd_val(rd_vals[c]),
      .sat(sat_flag[c]),
      .total(ev_total[32*c +: 32])
    );
  end
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d = !rd_en ? rd_data_q : int'(rd_ch) < NUM_CH ? rd_vals[rd_ch] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      run_q <= run_program;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: doc/driver_gap_histogram.md
Name: driver_gap_histogram

Overview:
- Multi-channel successor to the driver's per-FIFO cycle monitors.
- For each of NUM_CH event strobes (e.g. addr_fifo_rd, vctr_fifo_rd, addr_fifo_wr, vctr_fifo_wr), measures the cycle gap between consecutive events while a program runs.
- Bins each gap into a histogram of saturating counters, with a dedicated overflow bin.
- Histogram is readable through a 1-cycle-latency read port; also keeps sticky saturation flags and 32-bit per-channel event totals for driver_cntrl register readback.

Parameters:
- NUM_CH, 4, number of independent event channels (>=1).
- CNT_RANGE, 8, cycles per histogram bin (power of 2).
- CNT_SIZE, 16, width of each bin counter.
- MAX_CYCLE_CNT, 128, gap limit in cycles; multiple of CNT_RANGE.
- Derived localparams: NUM_BINS=MAX_CYCLE_CNT/CNT_RANGE; BIN_W=$clog2(NUM_BINS+1); CH_W=max(1,$clog2(NUM_CH)); GAP_W=$clog2(MAX_CYCLE_CNT+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run_program  in  1  level; histogram update enabled while high.
- hist_clear  in  1  single-cycle pulse; zeroes all bins, totals and flags.
- ev  in  NUM_CH  per-channel event strobe; one event per high cycle.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  channel to read.
- rd_bin  in  BIN_W  bin to read; NUM_BINS selects the overflow bin.
- rd_data  out  CNT_SIZE  bin value.
- rd_valid  out  1  rd_data qualifier.
- sat_flag  out  NUM_CH  sticky: some bin of the channel has saturated.
- ev_total  out  32*NUM_CH  per-channel events counted while armed; channel c at bits [32c+31:32c].

Behaviour:
- Reset: all bins, ev_total, sat_flag, rd_data, rd_valid = 0; every channel un-primed; gap counters = 0.
- Arming: run_program rising edge (registered previous value 0, current 1) un-primes all channels and zeroes gap counters in that cycle. An ev in that same cycle primes its channel but is not binned.
- Per channel, while run_program=1:
  - gap counter increments each cycle without ev; saturates at MAX_CYCLE_CNT, never wraps.
  - On ev when un-primed: channel becomes primed, gap counter := 1, no bin update.
  - On ev when primed: bin index = gap/CNT_RANGE if gap < MAX_CYCLE_CNT, else NUM_BINS (overflow). That bin increments by 1; gap counter := 1. Gap is measured strobe-to-strobe, so back-to-back events give gap 1 -> bin 0.
  - ev_total increments on every ev while run_program=1 (primed or not). It wraps at 2^32.
- run_program=0: no bin, total, or gap updates; histogram contents are retained (frozen for readback); primed state is cleared.
- Bin saturation: a counter at 2^CNT_SIZE-1 holds its value and sets sat_flag[c] (sticky until reset or hist_clear).
- hist_clear: next cycle all bins, ev_total and sat_flag are 0; gap counters = 0; all channels un-primed. If asserted with ev in the same cycle, the clear wins and the event is dropped. Any rd_data returned in that cycle reflects pre-clear contents.
- Read: rd_en in cycle N -> rd_valid=1 and rd_data in cycle N+1, value as stored at end of cycle N (pre-update if the same bin increments in cycle N). rd_valid=0 otherwise; rd_data holds its last value.
- Out-of-range rd_ch (>=NUM_CH) or rd_bin (>NUM_BINS) returns rd_data=0 with rd_valid=1.
- Channels are fully independent; simultaneous events on all channels are each processed in the same cycle.

Decomposition:
- Package driver_mon_pkg: clog2-derived width helpers and the bin-index function (gap -> bin with overflow clamp). Both are shared with driver_monitor.
- Sub-module gap_hist_chan: one channel's gap counter, primed flag, bin array, saturation and total. The top generates NUM_CH instances and muxes the registered read port.

Test Plan:
- Reset, then run_program=1; ev on ch0 at cycles 10,11,20,30 -> ch0 bin0=1 (gap 1), bin1=2 (gaps 9,10); ev_total[0]=4; other channels all 0.
- Primed ch1, then 200 cycles idle, then ev -> overflow bin (rd_bin=16 at defaults) =1; gap counter holds at 128, no wrap.
- CNT_SIZE=4 build: 20 events with gap 2 on ch2 -> bin0=15, sat_flag[2]=1; other sat_flag bits 0.
- hist_clear pulsed with ev on ch3 in the same cycle -> all bins/totals 0 next cycle; that ev is not counted; the next ev only primes ch3.
- rd_en on ch0 bin1 in the same cycle as a ch0 bin1 increment (value 2->3) -> rd_valid next cycle, rd_data=2; repeat read -> 3.
- run_program deasserted mid-stream -> contents frozen and readable; re-assert -> first ev per channel only primes it, no bin change.
